mdu_ctrl: RTL
=============

# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core, sitting in the E stage beside the ALU. It owns the HI/LO registers and sequences multi-cycle mult/multu/div/divu operations with a fixed, parameterised latency. It executes mthi/mtlo/mfhi/mflo, and generates the stall request that holds MD-class instructions in D while a multi-cycle operation is pending.

## Interface
- MULT_CYCLES, default 5: busy duration for mult/multu; must be ≥1.
- DIV_CYCLES, default 10: busy duration for div/divu; must be ≥1.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk, clears state when 0.
- start  in  1  E-stage MD instruction valid this cycle.
- md_op  in  4  operation, qualified by start: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- d_is_md  in  1  D-stage instruction is any MD-class op (codes 1–8).
- busy  out  1  multi-cycle operation in progress.
- stall_md  out  1  stall request to the hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  read data for mfhi/mflo.

## Operation
- States: IDLE, RUN. Internal: 32-bit cycle counter, 64-bit pending result {p_hi, p_lo}.
- IDLE with start=1 and md_op in 1–4:
  - Compute the result combinationally from a and b, and latch it into the pending registers.
  - Load the counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
  - Go to RUN.
- mult: signed 32×32→64, {hi,lo} = product. multu: the same, unsigned.
- div: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b=0, op 3 or 4): full DIV_CYCLES busy period; hi/lo are left unchanged at completion.
- RUN: counter decrements every cycle. In the cycle where counter==1, hi/lo ← pending at the edge and the state returns to IDLE.
- IDLE with start=1, md_op 7: hi ← a. md_op 8: lo ← a. Both take effect at the edge, with no busy.
- md_op 5/6: no state change. md_out = hi (5) or lo (6), combinationally; md_out = 0 for any other op.
- start=1 while in RUN: ignored entirely; no latch and no HI/LO write. The hazard unit guarantees this does not happen in legal flow.
- busy = (state == RUN).
- stall_md = d_is_md & (busy | (start & md_op in 1–4)).

## Timing
- Reset (reset=0 at an edge):
  - state IDLE, counter 0, pending 0, hi=0, lo=0.
  - busy=0; stall_md is then purely combinational from its inputs.
- Reset asserted mid-RUN aborts the operation: pending result is discarded, HI/LO are cleared, busy=0 after that edge.
- Latency for an op started in cycle 0 (start=1), with N = MULT_CYCLES or DIV_CYCLES:
  - busy=1 in cycles 1..N.
  - New hi/lo are visible from cycle N+1.
  - busy=0 in cycle N+1.
- A new op may start in cycle N+1. Back-to-back ops produce no busy gap beyond one IDLE cycle.
- mthi/mtlo in cycle k: mfhi/mflo in cycle k+1 returns the new value. No same-cycle bypass.
- Operands a/b are sampled only in the start cycle. Later changes on a/b never affect the result.
- md_out is valid in the same cycle as md_op, from registered hi/lo.

## Test plan
- Reset, then mult with a=0xFFFFFFFE (−2), b=3, MULT_CYCLES=5:
  - busy high in cycles 1–5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA from cycle 6.
- multu with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div cases, each with 10 busy cycles:
  - a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu 7/0 with prior hi=0x11, lo=0x22 -> hi/lo unchanged.
- div started, d_is_md=1 throughout:
  - stall_md=1 in cycle 0 and cycles 1–10, 0 in cycle 11.
  - With d_is_md=0, stall_md=0 throughout.
- start with md_op=1 in cycle 3 during a RUN begun in cycle 0 (DIV) -> ignored; final hi/lo match the div only, and busy falls at cycle 11.
- reset=0 in cycle 4 of a div -> hi=lo=0 and busy=0 from cycle 5. Then mtlo a=0x1234 in cycle 6 -> mflo in cycle 7 returns md_out=0x1234.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller for the E stage of the MIPS core.
//
// Owns the architectural HI/LO registers. mult/multu/div/divu compute their
// 64-bit result combinationally in the start cycle and park it in a pending
// register. A fixed-length busy window follows, and at its end the result is
// committed to HI/LO. mthi/mtlo write HI/LO directly at the edge. mfhi/mflo
// read the registered HI/LO combinationally on md_out.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous active-low reset
//   start        in   1   E-stage MD instruction valid
//   md_op        in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                         7 mthi,8 mtlo, 9-15 none
//   a, b         in   32  rs / rt operands (forwarded), sampled at start only
//   d_is_md      in   1   D-stage instruction is MD-class
//   busy         out  1   multi-cycle operation in progress
//   stall_md     out  1   stall request to the hazard unit
//   hi, lo       out  32  HI / LO registers
//   md_out       out  32  mfhi/mflo read data, 0 for other ops
//   dbg_state_o  out  1   FSM state (0 IDLE, 1 RUN) for checkers
//
// Handshake: there is no ready/valid back-pressure. start qualifies md_op for
// exactly one cycle. The hazard unit uses stall_md to keep further MD ops out
// of E while busy is high. A start seen during RUN is dropped entirely.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out,
  output logic        dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        skip_q, skip_d;   // divide by zero: do not commit at the end
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Shared arithmetic. One 64-bit multiplier handles both signednesses by
  // choosing sign- or zero-extension. One unsigned divider handles both
  // divides: signed division is done on magnitudes and the signs are fixed up
  // afterwards. This also makes 0x80000000 / -1 come out as 0x80000000 rem 0
  // without relying on the tool's overflow behaviour.
  // ---------------------------------------------------------------------------
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, product;
  logic        div_signed;
  logic [31:0] mag_a, mag_b, div_n, div_d, uq, ur, quo, rem;
  logic        b_zero;

  always_comb begin
    mul_signed = (md_op == OP_MULT);
    mul_a      = {(mul_signed ? {32{a[31]}} : 32'h0), a};
    mul_b      = {(mul_signed ? {32{b[31]}} : 32'h0), b};
    product    = mul_a * mul_b;

    div_signed = (md_op == OP_DIV);
    b_zero     = (b == 32'h0);
    mag_a      = a[31] ? (32'h0 - a) : a;
    mag_b      = b[31] ? (32'h0 - b) : b;
    div_n      = div_signed ? mag_a : a;
    div_d      = div_signed ? mag_b : b;
    // Guard the divisor so the divider never sees zero; the result is
    // discarded in that case anyway.
    if (b_zero) begin
      uq = 32'h0;
      ur = 32'h0;
    end else begin
      uq = div_n / div_d;
      ur = div_n % div_d;
    end
    quo = (div_signed && (a[31] ^ b[31])) ? (32'h0 - uq) : uq;
    rem = (div_signed && a[31])           ? (32'h0 - ur) : ur;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              p_hi_d  = product[63:32];
              p_lo_d  = product[31:0];
              cnt_d   = 32'(MULT_CYCLES);
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              p_hi_d  = rem;
              p_lo_d  = quo;
              cnt_d   = 32'(DIV_CYCLES);
              skip_d  = b_zero;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 32'd1;
        // <= 1 rather than == 1 so a zero count can never strand the FSM.
        if (cnt_q <= 32'd1) begin
          cnt_d   = 32'h0;
          state_d = S_IDLE;
          if (!skip_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'h0;
      p_hi_q  <= 32'h0;
      p_lo_q  <= 32'h0;
      skip_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  logic start_long;

  always_comb begin
    start_long  = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    busy        = (state_q == S_RUN);
    // Stall the D-stage MD op both while busy and in the cycle a long op is
    // issuing, since that op will be busy from the next cycle on.
    stall_md    = d_is_md && (busy || start_long);
    hi          = hi_q;
    lo          = lo_q;
    dbg_state_o = state_q;
    case (md_op)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'h0;
    endcase
  end

endmodule
